// File: rtl/ddr3_burst_scheduler_if.sv
// ddr3_app_if: DDR3 IP user-interface command, write-data and read-valid signals
interface ddr3_app_if #(parameter int ADDR_WIDTH = 28);
   logic                  app_en;
   logic [2:0]            app_cmd;
   logic [ADDR_WIDTH-1:0] app_addr;
   logic                  app_rdy;
   logic                  app_wdf_wren;
   logic                  app_wdf_end;
   logic                  app_wdf_rdy;
   logic                  app_rd_data_valid;
   modport master (
      output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end,
      input  app_rdy, app_wdf_rdy, app_rd_data_valid
   );
   modport slave (
      input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end,
      output app_rdy, app_wdf_rdy, app_rd_data_valid
   );
endinterface

// File: rtl/ddr3_burst_scheduler.sv
// ddr3_burst_scheduler: round-robin write/read burst sequencer using DDR3 as a ring buffer
module ddr3_burst_scheduler #(
   parameter int ADDR_WIDTH  = 28,
   parameter int BURST_BEATS = 16,
   parameter int ADDR_STEP   = 8,
   parameter int RING_BURSTS = 1024,
   parameter int BASE_ADDR   = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          init_calib_complete,
   input  logic [15:0]                   wr_fifo_level,
   output logic                          wr_fifo_rd_en,
   input  logic [15:0]                   rd_fifo_space,
   ddr3_app_if.master                    app,
   output logic [$clog2(RING_BURSTS):0]  ddr_fill,
   output logic                          busy
);
   localparam int PW = $clog2(RING_BURSTS);
   localparam int BW = $clog2(BURST_BEATS);
   localparam int FW = PW + 1;
   localparam logic [BW-1:0]         LAST_BEAT = BW'(BURST_BEATS - 1);
   localparam logic [15:0]           BEATS16   = 16'(BURST_BEATS);
   localparam logic [FW-1:0]         RING_FULL = FW'(RING_BURSTS);
   localparam logic [ADDR_WIDTH-1:0] A_BASE    = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] A_STEP    = ADDR_WIDTH'(ADDR_STEP);

   typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

   state_t        state, state_nx;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [BW-1:0] beat_cnt;
   logic [16:0]   rd_inflight;
   logic          last_grant_rd;
   logic          wr_ok, rd_ok, beat_done, last_beat, rd_accept, rd_return;

   // Eligibility (only consumed in IDLE) and beat handshake decode
   always_comb begin
      wr_ok     = init_calib_complete && wr_fifo_level >= BEATS16 && ddr_fill < RING_FULL;
      rd_ok     = init_calib_complete && ddr_fill != '0 &&
                  {2'b0, rd_fifo_space} >= 18'(BURST_BEATS) + {1'b0, rd_inflight};
      beat_done = (state == WR_BURST && app.app_rdy && app.app_wdf_rdy) ||
                  (state == RD_BURST && app.app_rdy);
      last_beat = beat_done && beat_cnt == LAST_BEAT;
      rd_accept = state == RD_BURST && app.app_rdy;
      rd_return = app.app_rd_data_valid && rd_inflight != '0;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   // Next state: round-robin grant in IDLE, back to IDLE after the last beat
   always_comb begin
      state_nx = state;
      if (state == IDLE)
         state_nx = (wr_ok && (!rd_ok || last_grant_rd)) ? WR_BURST : rd_ok ? RD_BURST : IDLE;
      else if (last_beat)
         state_nx = IDLE;
   end

   // Outputs decoded from state; address derived from the active ring pointer and beat
   always_comb begin
      app.app_en       = state != IDLE;
      app.app_cmd      = {2'b00, state == RD_BURST};
      app.app_wdf_wren = state == WR_BURST;
      app.app_wdf_end  = state == WR_BURST;
      app.app_addr     = state == IDLE ? '0 :
                         A_BASE + ADDR_WIDTH'({(state == RD_BURST ? rd_ptr : wr_ptr), beat_cnt}) * A_STEP;
      wr_fifo_rd_en    = state == WR_BURST && app.app_rdy && app.app_wdf_rdy;
      busy             = state != IDLE;
   end

   // Beat counter, grant history, ring pointers, fill level and outstanding read words
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         beat_cnt      <= '0;
         last_grant_rd <= 1'b1;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         ddr_fill      <= '0;
         rd_inflight   <= '0;
      end else begin
         if (state == IDLE && state_nx != IDLE) begin
            last_grant_rd <= state_nx == RD_BURST;
            beat_cnt      <= '0;
         end else if (beat_done)
            beat_cnt <= beat_cnt + 1'b1;
         if (last_beat && state == WR_BURST) begin
            wr_ptr   <= wr_ptr + 1'b1;
            ddr_fill <= ddr_fill + 1'b1;
         end
         if (last_beat && state == RD_BURST) begin
            rd_ptr   <= rd_ptr + 1'b1;
            ddr_fill <= ddr_fill - 1'b1;
         end
         rd_inflight <= rd_inflight + {16'b0, rd_accept} - {16'b0, rd_return};
      end
endmodule

// File: tb/tb_ddr3_burst_scheduler.sv
// tb_ddr3_burst_scheduler: scoreboard bench with a small DDR model behind the app interface
module tb_ddr3_burst_scheduler;
   localparam int AW = 28, BEATS = 16, STEP = 8, RING = 4;

   typedef struct { int cmd; int addr; int data; } beat_t;
   typedef struct { int data; int due; } resp_t;

   logic        clk = 0, rst_n = 1, calib = 0;
   logic        rdy = 1, wdf_rdy = 1, rvalid = 0;
   logic [15:0] wr_fifo_level, rd_fifo_space = 0;
   logic        wr_fifo_rd_en, busy;
   logic [2:0]  ddr_fill;
   int pushed = 0, popped = 0, cyc = 0, rdata = 0;
   int checks = 0, errors = 0;
   int nbeats = 0, en_cnt = 0, busy_cnt = 0;
   int m_wr_ptr = 0, m_rd_ptr = 0, m_word = 0;
   beat_t exp_q[$];
   int    rexp_q[$];
   resp_t resp_q[$];
   int    mem[int];
   int    ring_data[int];
   beat_t mb;
   resp_t mr, dr;

   ddr3_app_if #(.ADDR_WIDTH(AW)) app ();
   assign app.app_rdy           = rdy;
   assign app.app_wdf_rdy       = wdf_rdy;
   assign app.app_rd_data_valid = rvalid;
   assign wr_fifo_level         = 16'(pushed - popped);

   ddr3_burst_scheduler #(.ADDR_WIDTH(AW), .BURST_BEATS(BEATS), .ADDR_STEP(STEP),
                          .RING_BURSTS(RING), .BASE_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .init_calib_complete(calib),
      .wr_fifo_level(wr_fifo_level), .wr_fifo_rd_en(wr_fifo_rd_en),
      .rd_fifo_space(rd_fifo_space), .app(app), .ddr_fill(ddr_fill), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (wr_fifo_rd_en) popped <= popped + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push_burst(input int cmd);
      int p = cmd ? m_rd_ptr : m_wr_ptr;
      for (int i = 0; i < BEATS; i++) begin
         int a = (p * BEATS + i) * STEP;
         beat_t b;
         b.cmd  = cmd;
         b.addr = a;
         if (cmd == 0) begin
            b.data       = m_word;
            ring_data[a] = m_word;
            m_word++;
         end else b.data = ring_data[a];
         exp_q.push_back(b);
      end
      if (cmd) m_rd_ptr = (m_rd_ptr + 1) % RING;
      else     m_wr_ptr = (m_wr_ptr + 1) % RING;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0 && rexp_q.size() == 0 && resp_q.size() == 0 && !busy) return;
      end
      chk({tag, "_timeout"}, 0, 1);
   endtask

   task automatic wait_busy(input string tag);
      for (int i = 0; i < 200; i++) begin
         if (busy) return;
         @(posedge clk); #1;
      end
      chk({tag, "_busy_timeout"}, 0, 1);
   endtask

   task automatic wait_beats(input string tag, input int target);
      for (int i = 0; i < 300; i++) begin
         if (nbeats >= target) return;
         @(posedge clk); #1;
      end
      chk({tag, "_beat_timeout"}, nbeats, target);
   endtask

   // Scoreboard monitor: accepted beats and returned read words
   always @(negedge clk) if (rst_n) begin
      if (app.app_en) en_cnt++;
      if (busy) busy_cnt++;
      if (app.app_en && rdy && (app.app_cmd == 3'd1 || wdf_rdy)) begin
         nbeats++;
         if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
         else begin
            mb = exp_q.pop_front();
            chk("cmd", 64'(app.app_cmd), mb.cmd);
            chk("addr", 64'(app.app_addr), mb.addr);
            if (mb.cmd == 0) begin
               chk("wr_pop", wr_fifo_rd_en, 1);
               chk("wdf_end", app.app_wdf_end, 1);
               chk("wdata", popped, mb.data);
               mem[int'(app.app_addr)] = popped;
            end else begin
               mr.data = mem.exists(int'(app.app_addr)) ? mem[int'(app.app_addr)] : -1;
               mr.due  = cyc + 5;
               resp_q.push_back(mr);
               rexp_q.push_back(mb.data);
            end
         end
      end
      if (rvalid) begin
         if (rexp_q.size() == 0) chk("unexpected_rdata", 1, 0);
         else chk("rdata", rdata, rexp_q.pop_front());
      end
   end

   // DDR read-return model: one word per clock after a fixed latency
   initial forever begin
      @(posedge clk); #1;
      rvalid = 0;
      if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
         dr     = resp_q.pop_front();
         rvalid = 1;
         rdata  = dr.data;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got %0d checks expected completion", checks);
      $fatal(1, "global timeout");
   end

   initial begin
      int p0, e0, b0, n;
      #1 rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_app_en", app.app_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fill", ddr_fill, 0);
      chk("rst_rd_en", wr_fifo_rd_en, 0);
      chk("rst_addr", 64'(app.app_addr), 0);
      rst_n = 1;

      // calibration low: nothing issued despite a full write FIFO
      pushed = 64;
      e0 = en_cnt; b0 = busy_cnt;
      repeat (1000) @(posedge clk);
      #1;
      chk("t1_app_en_cnt", en_cnt - e0, 0);
      chk("t1_busy_cnt", busy_cnt - b0, 0);
      pushed = popped;

      // single write burst at full rate
      calib = 1;
      p0 = popped;
      push_burst(0);
      pushed += 16;
      wait_busy("t2");
      n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t2_burst_cycles", n, 16);
      wait_idle("t2");
      chk("t2_pops", popped - p0, 16);
      chk("t2_fill", ddr_fill, 1);

      // write burst with app_rdy stalled at beat 5
      p0 = popped;
      push_burst(0);
      pushed += 16;
      wait_beats("t3", nbeats + 5);
      rdy = 0;
      repeat (3) begin
         @(negedge clk);
         chk("t3_stall_en", app.app_en, 1);
         chk("t3_stall_addr", 64'(app.app_addr), (16 + 5) * 8);
         chk("t3_stall_wren", app.app_wdf_wren, 1);
         chk("t3_stall_pop", wr_fifo_rd_en, 0);
      end
      @(posedge clk); #1;
      rdy = 1;
      wait_idle("t3");
      chk("t3_pops", popped - p0, 16);
      chk("t3_fill", ddr_fill, 2);

      // both eligible: last grant was write, so read, write, read, write, then drain reads
      p0 = popped;
      push_burst(1); push_burst(0); push_burst(1); push_burst(0); push_burst(1); push_burst(1);
      pushed += 32;
      rd_fifo_space = 64;
      wait_idle("t4");
      chk("t4_fill", ddr_fill, 0);
      chk("t4_pops", popped - p0, 32);
      chk("t4_inflight", 64'(dut.rd_inflight), 0);

      // ring full: no write issued; one read frees a slot reused at address 0
      rd_fifo_space = 0;
      push_burst(0); push_burst(0); push_burst(0); push_burst(0);
      pushed += 64;
      wait_idle("t5a");
      chk("t5_fill_full", ddr_fill, 4);
      pushed += 64;
      e0 = en_cnt;
      repeat (50) @(posedge clk);
      #1;
      chk("t5_no_write_when_full", en_cnt - e0, 0);
      chk("t5_fill_hold", ddr_fill, 4);
      push_burst(1); push_burst(0);
      rd_fifo_space = 16;
      wait_busy("t5");
      rd_fifo_space = 0;
      wait_idle("t5b");
      chk("t5_fill_after", ddr_fill, 4);
      pushed = popped;

      // reset in the middle of a read burst
      push_burst(1);
      rd_fifo_space = 64;
      wait_beats("t6", nbeats + 7);
      rst_n = 0;
      #1;
      chk("t6_rst_en", app.app_en, 0);
      chk("t6_rst_cmd", 64'(app.app_cmd), 0);
      chk("t6_rst_addr", 64'(app.app_addr), 0);
      chk("t6_rst_wren", app.app_wdf_wren, 0);
      chk("t6_rst_pop", wr_fifo_rd_en, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_fill", ddr_fill, 0);
      exp_q.delete(); rexp_q.delete(); resp_q.delete();
      m_wr_ptr = 0; m_rd_ptr = 0;
      rd_fifo_space = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("t6_inflight", 64'(dut.rd_inflight), 0);
      rst_n = 1;
      push_burst(0);
      pushed += 16;
      wait_idle("t6");
      chk("t6_fill", ddr_fill, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
